// File: rtl/mnist_nn_debug_cmd_decoder.sv
// mnist_nn_debug_cmd_decoder: virtual-JTAG IR/DR shift registers with per-channel command issue
//   clk, reset         : clock, synchronous active-high reset
//   tck_en             : TCK rising-edge strobe qualifying all state inputs
//   tdi / tdo          : serial in / serial out (tdo = sr[0])
//   state_uir/udr/cdr/sdr : update-IR, update-DR, capture-DR, shift-DR (priority in that order)
//   ir_in              : instruction presented at update-IR
//   capture_data       : NUM_CH readback words, channel k at [k*DR_W +: DR_W]
//   jdo                : last accepted command word
//   act_valid/act_take : per-channel pending command and its take qualifier
//   act_ready          : per-channel consumer accept
//   overrun/overrun_clr: sticky per-channel dropped-command flags and their clear
//   cmd_count          : accepted-command counter (wraps)
module mnist_nn_debug_cmd_decoder #(
   parameter int DR_W    = 38,
   parameter int IR_W    = 2,
   parameter int NUM_CH  = 4,
   parameter int ACT_BIT = DR_W - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tck_en,
   input  logic                     tdi,
   output logic                     tdo,
   input  logic                     state_uir,
   input  logic                     state_udr,
   input  logic                     state_cdr,
   input  logic                     state_sdr,
   input  logic [IR_W-1:0]          ir_in,
   input  logic [NUM_CH*DR_W-1:0]   capture_data,
   output logic [DR_W-1:0]          jdo,
   output logic [NUM_CH-1:0]        act_valid,
   output logic [NUM_CH-1:0]        act_take,
   input  logic [NUM_CH-1:0]        act_ready,
   output logic [NUM_CH-1:0]        overrun,
   input  logic                     overrun_clr,
   output logic [15:0]              cmd_count
);
   logic [IR_W-1:0]   ir_q;
   logic [DR_W-1:0]   sr;
   logic              uir, udr, cdr, sdr, in_range, busy, accept, drop;
   logic [NUM_CH-1:0] sel;
   assign tdo = sr[0];
   always_comb begin
      uir      = tck_en & state_uir;
      udr      = tck_en & ~state_uir & state_udr;
      cdr      = tck_en & ~state_uir & ~state_udr & state_cdr;
      sdr      = tck_en & ~state_uir & ~state_udr & ~state_cdr & state_sdr;
      in_range = 32'(ir_q) < NUM_CH;
      sel      = in_range ? NUM_CH'(1) << ir_q : '0;
      // an acked channel frees the slot in the same cycle, so it never counts as busy
      busy     = |(act_valid & ~act_ready);
      accept   = udr & in_range & ~busy;
      drop     = udr & in_range & busy;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q      <= '0;
         sr        <= '0;
         jdo       <= '0;
         act_valid <= '0;
         act_take  <= '0;
         overrun   <= '0;
         cmd_count <= '0;
      end else begin
         if (uir) ir_q <= ir_in;
         // out-of-range channels shift past the top of capture_data and load 0
         if (cdr) sr <= DR_W'(capture_data >> (32'(ir_q) * DR_W));
         else if (sdr) sr <= {tdi, sr[DR_W-1:1]};
         if (accept) begin
            jdo       <= sr;
            cmd_count <= cmd_count + 16'd1;
         end
         act_valid <= (act_valid & ~act_ready) | (accept ? sel : '0);
         act_take  <= accept ? (act_take & ~sel) | (sel & {NUM_CH{sr[ACT_BIT]}}) : act_take;
         overrun   <= (overrun_clr ? '0 : overrun) | (drop ? sel : '0);
      end
   end
endmodule

// File: tb/tb_mnist_nn_debug_cmd_decoder.sv
// tb_mnist_nn_debug_cmd_decoder: self-checking bench, 4-channel and 3-channel instances against a reference model
module tb_mnist_nn_debug_cmd_decoder;
   localparam int DR_W = 38;
   localparam int IR_W = 2;
   logic clk = 1'b0;
   logic reset, tck_en, tdi, state_uir, state_udr, state_cdr, state_sdr, overrun_clr;
   logic [IR_W-1:0]   ir_in;
   logic [4*DR_W-1:0] capture_data;
   logic [3:0]        act_ready;
   logic              tdo_a, tdo_b;
   logic [DR_W-1:0]   jdo_a, jdo_b;
   logic [3:0]        act_valid_a, act_take_a, overrun_a;
   logic [2:0]        act_valid_b, act_take_b, overrun_b;
   logic [15:0]       cmd_count_a, cmd_count_b;
   int n_chk = 0;
   int n_fail = 0;
   logic [DR_W-1:0] m_sr[2], m_jdo[2];
   int m_ir[2], m_cnt[2];
   bit m_v[2][4], m_t[2][4], m_o[2][4];

   always #5 clk = ~clk;

   mnist_nn_debug_cmd_decoder #(.DR_W(DR_W), .IR_W(IR_W), .NUM_CH(4)) u_a (
      .clk(clk), .reset(reset), .tck_en(tck_en), .tdi(tdi), .tdo(tdo_a),
      .state_uir(state_uir), .state_udr(state_udr), .state_cdr(state_cdr), .state_sdr(state_sdr),
      .ir_in(ir_in), .capture_data(capture_data), .jdo(jdo_a), .act_valid(act_valid_a),
      .act_take(act_take_a), .act_ready(act_ready), .overrun(overrun_a),
      .overrun_clr(overrun_clr), .cmd_count(cmd_count_a));

   mnist_nn_debug_cmd_decoder #(.DR_W(DR_W), .IR_W(IR_W), .NUM_CH(3)) u_b (
      .clk(clk), .reset(reset), .tck_en(tck_en), .tdi(tdi), .tdo(tdo_b),
      .state_uir(state_uir), .state_udr(state_udr), .state_cdr(state_cdr), .state_sdr(state_sdr),
      .ir_in(ir_in), .capture_data(capture_data[3*DR_W-1:0]), .jdo(jdo_b), .act_valid(act_valid_b),
      .act_take(act_take_b), .act_ready(act_ready[2:0]), .overrun(overrun_b),
      .overrun_clr(overrun_clr), .cmd_count(cmd_count_b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model: one call per clock edge for instance i (i=0: 4 channels, i=1: 3 channels)
   task automatic step(input int i);
      int n;
      bit busy;
      n = (i == 0) ? 4 : 3;
      busy = 0;
      if (reset) begin
         m_sr[i] = '0; m_jdo[i] = '0; m_ir[i] = 0; m_cnt[i] = 0;
         for (int k = 0; k < 4; k++) begin m_v[i][k] = 0; m_t[i][k] = 0; m_o[i][k] = 0; end
      end else begin
         for (int k = 0; k < n; k++) if (m_v[i][k] && !act_ready[k]) busy = 1;
         for (int k = 0; k < n; k++) if (act_ready[k]) m_v[i][k] = 0;
         if (overrun_clr) for (int k = 0; k < 4; k++) m_o[i][k] = 0;
         if (tck_en) begin
            if (state_uir) m_ir[i] = int'(ir_in);
            else if (state_udr) begin
               if (m_ir[i] < n) begin
                  if (!busy) begin
                     m_jdo[i] = m_sr[i];
                     m_v[i][m_ir[i]] = 1;
                     m_t[i][m_ir[i]] = m_sr[i][DR_W-1];
                     m_cnt[i] = (m_cnt[i] + 1) % 65536;
                  end else m_o[i][m_ir[i]] = 1;
               end
            end else if (state_cdr) m_sr[i] = (m_ir[i] < n) ? capture_data[m_ir[i]*DR_W +: DR_W] : '0;
            else if (state_sdr) begin
               m_sr[i] = m_sr[i] >> 1;
               m_sr[i][DR_W-1] = tdi;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         logic [3:0] ev, et, eo;
         ev = '0; et = '0; eo = '0;
         for (int k = 0; k < 4; k++) begin
            ev[k] = m_v[i][k];
            et[k] = m_t[i][k] & m_v[i][k];
            eo[k] = m_o[i][k];
         end
         if (i == 0) begin
            chk("tdo_a", 64'(tdo_a), 64'(m_sr[0][0]));
            chk("sr_a", 64'(u_a.sr), 64'(m_sr[0]));
            chk("jdo_a", 64'(jdo_a), 64'(m_jdo[0]));
            chk("valid_a", 64'(act_valid_a), 64'(ev));
            chk("take_a", 64'(act_take_a & act_valid_a), 64'(et));
            chk("overrun_a", 64'(overrun_a), 64'(eo));
            chk("count_a", 64'(cmd_count_a), 64'(m_cnt[0]));
         end else begin
            chk("tdo_b", 64'(tdo_b), 64'(m_sr[1][0]));
            chk("sr_b", 64'(u_b.sr), 64'(m_sr[1]));
            chk("jdo_b", 64'(jdo_b), 64'(m_jdo[1]));
            chk("valid_b", 64'(act_valid_b), 64'(ev[2:0]));
            chk("take_b", 64'(act_take_b & act_valid_b), 64'(et[2:0]));
            chk("overrun_b", 64'(overrun_b), 64'(eo[2:0]));
            chk("count_b", 64'(cmd_count_b), 64'(m_cnt[1]));
         end
      end
   endtask

   task automatic set_idle();
      reset = 0; tck_en = 0; tdi = 0; state_uir = 0; state_udr = 0; state_cdr = 0; state_sdr = 0;
      ir_in = '0; act_ready = '0; overrun_clr = 0;
   endtask

   task automatic tick(input bit do_chk = 1);
      @(posedge clk);
      step(0);
      step(1);
      #1;
      if (do_chk) check_all();
      set_idle();
   endtask

   task automatic rand_cap();
      for (int k = 0; k < 4; k++) capture_data[k*DR_W +: DR_W] = DR_W'({$urandom, $urandom});
   endtask

   task automatic rand_inputs();
      tck_en = ($urandom % 4) != 0;
      tdi = 1'($urandom);
      state_uir = ($urandom % 6) == 0;
      state_udr = ($urandom % 5) == 0;
      state_cdr = ($urandom % 6) == 0;
      state_sdr = ($urandom % 2) == 0;
      ir_in = IR_W'($urandom);
      act_ready = 4'($urandom);
      overrun_clr = ($urandom % 16) == 0;
      if (($urandom % 8) == 0) rand_cap();
   endtask

   task automatic do_uir(input int v);
      tck_en = 1; state_uir = 1; ir_in = IR_W'(v);
      tick();
   endtask

   task automatic shift_word(input logic [DR_W-1:0] w);
      for (int i = 0; i < DR_W; i++) begin
         tck_en = 1; state_sdr = 1; tdi = w[i];
         tick();
      end
   endtask

   task automatic do_udr(input logic [3:0] rdy, input bit clr);
      tck_en = 1; state_udr = 1; act_ready = rdy; overrun_clr = clr;
      tick();
   endtask

   initial begin
      logic [DR_W-1:0] w;
      set_idle();
      rand_cap();
      // reset with random inputs
      for (int c = 0; c < 3; c++) begin
         rand_inputs();
         reset = 1;
         tick();
      end
      chk("rst_valid", 64'(act_valid_a), 64'd0);
      chk("rst_count", 64'(cmd_count_a), 64'd0);
      chk("rst_tdo", 64'(tdo_a), 64'd0);
      // shift all ones
      for (int i = 0; i < DR_W; i++) begin
         tck_en = 1; state_sdr = 1; tdi = 1;
         tick();
      end
      chk("sr_ones", 64'(u_a.sr), 64'({DR_W{1'b1}}));
      chk("tdo_one", 64'(tdo_a), 64'd1);
      // capture/shift readback of channel 2
      w = 38'h2_1234_5678;
      capture_data[2*DR_W +: DR_W] = w;
      do_uir(2);
      tck_en = 1; state_cdr = 1;
      tick();
      chk("rb_bit0", 64'(tdo_a), 64'(w[0]));
      for (int i = 1; i < DR_W; i++) begin
         tck_en = 1; state_sdr = 1; tdi = 0;
         tick();
         chk("rb_bit", 64'(tdo_a), 64'(w[i]));
      end
      tck_en = 1; state_sdr = 1; tdi = 0;
      tick();
      chk("rb_empty", 64'(u_a.sr), 64'd0);
      // command issue on channel 1 and ack
      do_uir(1);
      shift_word(38'h20_0000_00AB);
      do_udr(4'b0000, 0);
      chk("cmd_jdo", 64'(jdo_a), 64'h20_0000_00AB);
      chk("cmd_valid", 64'(act_valid_a), 64'b0010);
      chk("cmd_take", 64'(act_take_a[1]), 64'd1);
      chk("cmd_count", 64'(cmd_count_a), 64'd1);
      act_ready = 4'b0010;
      tick();
      chk("ack_valid", 64'(act_valid_a), 64'd0);
      // overrun: ch1 left pending, update on ch3 is dropped
      shift_word(38'h1F_0000_0011);
      do_udr(4'b0000, 0);
      do_uir(3);
      shift_word(38'h0A_5A5A_5A5A);
      do_udr(4'b0000, 0);
      chk("ovr_set", 64'(overrun_a), 64'b1000);
      chk("ovr_jdo", 64'(jdo_a), 64'h1F_0000_0011);
      chk("ovr_count", 64'(cmd_count_a), 64'd2);
      chk("ovr_b_none", 64'(overrun_b), 64'd0);
      do_udr(4'b0000, 1);
      chk("ovr_set_wins", 64'(overrun_a), 64'b1000);
      overrun_clr = 1;
      tick();
      chk("ovr_clr", 64'(overrun_a), 64'd0);
      act_ready = 4'b0010;
      tick();
      // IR=3: out of range for the 3-channel instance
      tck_en = 1; state_cdr = 1;
      tick();
      chk("ir3_sr_b", 64'(u_b.sr), 64'd0);
      do_udr(4'b0000, 0);
      chk("ir3_valid_b", 64'(act_valid_b), 64'd0);
      chk("ir3_valid_a", 64'(act_valid_a), 64'b1000);
      act_ready = 4'b1000;
      tick();
      // simultaneous ack and update on channel 0
      do_uir(0);
      shift_word(38'h20_0000_0001);
      do_udr(4'b0000, 0);
      chk("sim_take1", 64'(act_take_a[0]), 64'd1);
      shift_word(38'h0F_0000_0002);
      do_udr(4'b0001, 0);
      chk("sim_valid", 64'(act_valid_a), 64'b0001);
      chk("sim_take0", 64'(act_take_a[0]), 64'd0);
      chk("sim_no_ovr", 64'(overrun_a), 64'd0);
      chk("sim_jdo", 64'(jdo_a), 64'h0F_0000_0002);
      act_ready = 4'b0001;
      tick();
      // reset in the middle of a shift
      for (int i = 0; i < 5; i++) begin
         tck_en = 1; state_sdr = 1; tdi = 1;
         tick();
      end
      reset = 1; tck_en = 1; state_sdr = 1; tdi = 1;
      tick();
      chk("rst_mid_sr", 64'(u_a.sr), 64'd0);
      chk("rst_mid_tdo", 64'(tdo_a), 64'd0);
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         reset = ($urandom % 200) == 0;
         tick();
      end
      // counter wrap
      reset = 1;
      tick();
      do_uir(0);
      for (int c = 0; c < 65535; c++) begin
         tck_en = 1; state_udr = 1; act_ready = 4'b0001;
         tick(0);
      end
      check_all();
      chk("cnt_max", 64'(cmd_count_a), 64'hFFFF);
      do_udr(4'b0001, 0);
      chk("cnt_wrap", 64'(cmd_count_a), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
